// File: rtl/gpioemu_mulpop_if.sv
// Register-bus bundle for gpioemu_mulpop: address, one-cycle read/write strobes,
// write data and registered read data.
interface gpioemu_mulpop_if;
  // Strobe protocol: srd/swr are single-cycle strobes sampled on posedge clk.
  // There is no back-pressure. Read data appears on sdata_out after the edge
  // that samples srd and holds until the next read.
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;

  modport master (output saddress, output srd, output swr, output sdata_in,
                  input sdata_out);
  modport slave  (input saddress, input srd, input swr, input sdata_in,
                  output sdata_out);
endinterface

// File: rtl/gpioemu_mulpop.sv
// Bus-mapped serial shift-add multiplier with popcount, status flags, op counter and GPIO snapshot.
// Optional macro GPIOEMU_MULPOP_SAT_EN: saturate W to all ones on overflow instead of truncating.
module gpioemu_mulpop #(
  parameter logic [15:0] BASE_ADDR = 16'h0380,
  parameter int          OP_W      = 24,
  parameter int          RES_W     = 32,
  parameter int          CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    n_reset,
  gpioemu_mulpop_if.slave         bus,
  input  logic [31:0]             gpio_in,
  input  logic                    gpio_latch,
  output logic [31:0]             gpio_out,
  output logic [31:0]             gpio_in_s_insp,
  output logic [1:0]              state_dbg
);
  localparam int AW = (2 * OP_W > RES_W) ? 2 * OP_W : RES_W;
  localparam int IW = $clog2(OP_W);
  localparam logic [15:0] ADDR_A1   = BASE_ADDR + 16'h0000;
  localparam logic [15:0] ADDR_A2   = BASE_ADDR + 16'h0008;
  localparam logic [15:0] ADDR_W    = BASE_ADDR + 16'h0010;
  localparam logic [15:0] ADDR_L    = BASE_ADDR + 16'h0018;
  localparam logic [15:0] ADDR_CTRL = BASE_ADDR + 16'h0020;

  typedef enum logic [1:0] {IDLE, MULT, COUNT, DONE} state_t;
  state_t state_q, state_d;

  logic [OP_W-1:0]  a1_q, a1_d, a2_q, a2_d, mplier_q, mplier_d;
  logic [AW-1:0]    mcand_q, mcand_d, acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [RES_W-1:0] w_q, w_d, w_new;
  logic [5:0]       l_q, l_d, l_new;
  logic             ready_q, ready_d, valid_q, valid_d, ovf;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      gpio_in_s_q, gpio_in_s_d, sdata_out_q, sdata_out_d;
  logic             start_go, step, last, do_count, do_done, busy;
  logic [31:0]      unused_wdata;

  assign unused_wdata = bus.sdata_in;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_go) state_d = MULT;
      MULT:    if (last) state_d = COUNT;
      COUNT:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Start is only honoured from IDLE; a start write at any other time is dropped.
  always_comb begin
    busy     = (state_q != IDLE);
    start_go = (state_q == IDLE) && bus.swr && (bus.saddress == ADDR_CTRL);
    step     = (state_q == MULT);
    last     = step && (idx_q == IW'(OP_W - 1));
    do_count = (state_q == COUNT);
    do_done  = (state_q == DONE);
  end

  always_comb begin
    ovf = (acc_q >> RES_W) != '0;
`ifdef GPIOEMU_MULPOP_SAT_EN
    w_new = ovf ? '1 : acc_q[RES_W-1:0];
`else
    w_new = acc_q[RES_W-1:0];
`endif
    l_new = '0;
    for (int i = 0; i < RES_W; i++) l_new = l_new + 6'(w_new[i]);
  end

  always_comb begin
    a1_d        = a1_q;
    a2_d        = a2_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    w_d         = w_q;
    l_d         = l_q;
    ready_d     = ready_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    gpio_in_s_d = gpio_in_s_q;
    sdata_out_d = sdata_out_q;

    if (bus.swr && bus.saddress == ADDR_A1) a1_d = bus.sdata_in[OP_W-1:0];
    if (bus.swr && bus.saddress == ADDR_A2) a2_d = bus.sdata_in[OP_W-1:0];

    if (start_go) begin
      mcand_d  = AW'(a1_q);
      mplier_d = a2_q;
      acc_d    = '0;
      idx_d    = '0;
      ready_d  = 1'b0;
      valid_d  = 1'b0;
    end
    // One multiplier bit per cycle: multiplicand shifts up as multiplier shifts down.
    if (step) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      idx_d    = idx_q + 1'b1;
    end
    if (do_count) begin
      w_d     = w_new;
      l_d     = l_new;
      valid_d = !ovf;
    end
    if (do_done) begin
      ready_d = 1'b1;
      cnt_d   = cnt_q + 1'b1;
    end

    if (gpio_latch) gpio_in_s_d = gpio_in;

    // Register values before this edge are returned, so read-during-write sees old data.
    if (bus.srd) begin
      case (bus.saddress)
        ADDR_A1:   sdata_out_d = 32'(a1_q);
        ADDR_A2:   sdata_out_d = 32'(a2_q);
        ADDR_W:    sdata_out_d = ready_q ? 32'(w_q) : 32'h0;
        ADDR_L:    sdata_out_d = ready_q ? 32'(l_q) : 32'h0;
        ADDR_CTRL: sdata_out_d = {29'b0, busy, ready_q, valid_q};
        default:   sdata_out_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a1_q        <= '0;
      a2_q        <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      w_q         <= '0;
      l_q         <= '0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      gpio_in_s_q <= '0;
      sdata_out_q <= '0;
    end else begin
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      w_q         <= w_d;
      l_q         <= l_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      gpio_in_s_q <= gpio_in_s_d;
      sdata_out_q <= sdata_out_d;
    end
  end

  assign bus.sdata_out   = sdata_out_q;
  assign gpio_out        = 32'(cnt_q);
  assign gpio_in_s_insp  = gpio_in_s_q;
  assign state_dbg       = state_q;
endmodule

// File: tb/tb_gpioemu_mulpop.sv
// Directed bench for gpioemu_mulpop: bus reads are scored from an expected queue by a
// monitor; a second instance with CNT_W=2 shares the stimulus to exercise counter wrap.
module tb_gpioemu_mulpop;
  localparam int OP_W = 24;
  localparam logic [15:0] A_A1 = 16'h0380, A_A2 = 16'h0388, A_W = 16'h0390,
                          A_L = 16'h0398, A_CTRL = 16'h03A0, A_BAD = 16'h03A8;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [31:0] gpio_in = '0;
  logic        gpio_latch = 1'b0;
  logic [31:0] gpio_out, gpio_in_s_insp, gpio_out2, gpio_in_s_insp2;
  logic [1:0]  state_dbg, state_dbg2;

  gpioemu_mulpop_if bus ();
  gpioemu_mulpop_if bus2 ();

  assign bus2.saddress = bus.saddress;
  assign bus2.srd      = bus.srd;
  assign bus2.swr      = bus.swr;
  assign bus2.sdata_in = bus.sdata_in;

  gpioemu_mulpop u_dut (
    .clk(clk), .n_reset(n_reset), .bus(bus), .gpio_in(gpio_in), .gpio_latch(gpio_latch),
    .gpio_out(gpio_out), .gpio_in_s_insp(gpio_in_s_insp), .state_dbg(state_dbg)
  );

  gpioemu_mulpop #(.CNT_W(2)) u_dut2 (
    .clk(clk), .n_reset(n_reset), .bus(bus2), .gpio_in(gpio_in), .gpio_latch(gpio_latch),
    .gpio_out(gpio_out2), .gpio_in_s_insp(gpio_in_s_insp2), .state_dbg(state_dbg2)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard
  logic [31:0] exp_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (n_reset && bus.srd) begin
      #1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got 0x%08h expected no read", bus.sdata_out);
      end else begin
        chk(name_q.pop_front(), bus.sdata_out, exp_q.pop_front());
      end
    end
  end

  // Driver tasks: called at a negedge, hold strobes across exactly one posedge.
  task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp, input string name);
    if (rd) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    bus.srd = rd;
    bus.swr = wr;
    bus.saddress = addr;
    bus.sdata_in = wdata;
    @(negedge clk);
    bus.srd = 1'b0;
    bus.swr = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] d);
    drive(1'b0, 1'b1, addr, d, 32'h0, "");
  endtask

  task automatic rd(input logic [15:0] addr, input logic [31:0] exp, input string name);
    drive(1'b1, 1'b0, addr, 32'h0, exp, name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_op(input logic [31:0] a1, input logic [31:0] a2);
    wr(A_A1, a1);
    wr(A_A2, a2);
    wr(A_CTRL, 32'h1);
    idle(OP_W + 4);
  endtask

  initial begin
    bus.srd = 1'b0;
    bus.swr = 1'b0;
    bus.saddress = '0;
    bus.sdata_in = '0;
    idle(3);
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_insp", gpio_in_s_insp, 32'h0);
    chk("rst_sdata_out", bus.sdata_out, 32'h0);
    n_reset = 1'b1;
    idle(2);
    rd(A_CTRL, 32'h0, "rst_status");

    // 3 x 5: busy through edge 26, ready/valid after
    wr(A_A1, 32'h3);
    wr(A_A2, 32'h5);
    wr(A_CTRL, 32'h0);
    for (int k = 1; k <= 27; k++) begin
      if (k <= 25)      rd(A_CTRL, 32'h4, "t1_busy_status");
      else if (k == 26) idle(1);
      else              rd(A_CTRL, 32'h3, "t1_done_status");
    end
    rd(A_W, 32'hF, "t1_w");
    rd(A_L, 32'h4, "t1_l");
    rd(A_A2, 32'h5, "t1_a2");
    chk("t1_gpio_out", gpio_out, 32'h1);

    // Overflow, with upper write bits dropped
    wr(A_A1, 32'hFFFF_FFFF);
    rd(A_A1, 32'h00FF_FFFF, "t2_a1_trunc");
    run_op(32'hFFFF_FFFF, 32'h00FF_FFFF);
    rd(A_CTRL, 32'h2, "t2_status");
`ifdef GPIOEMU_MULPOP_SAT_EN
    rd(A_W, 32'hFFFF_FFFF, "t2_w_sat");
    rd(A_L, 32'd32, "t2_l_sat");
`else
    rd(A_W, 32'hFE00_0001, "t2_w");
    rd(A_L, 32'd8, "t2_l");
`endif
    chk("t2_gpio_out", gpio_out, 32'h2);

    // Operand write and restart while busy are ignored by the running op
    wr(A_A1, 32'h9);
    wr(A_A2, 32'h11);
    wr(A_CTRL, 32'h1);
    idle(3);
    wr(A_A1, 32'h7);
    wr(A_CTRL, 32'h1);
    rd(A_W, 32'h0, "t3_w_not_ready");
    idle(OP_W + 4);
    rd(A_CTRL, 32'h3, "t3_status");
    rd(A_W, 32'h99, "t3_w");
    rd(A_L, 32'h4, "t3_l");
    rd(A_A1, 32'h7, "t3_a1");
    idle(2);
    chk("t3_gpio_out", gpio_out, 32'h3);

    // Reset mid-multiply
    wr(A_A1, 32'h5);
    wr(A_A2, 32'h6);
    wr(A_CTRL, 32'h1);
    idle(10);
    n_reset = 1'b0;
    #1;
    chk("t4_gpio_out", gpio_out, 32'h0);
    chk("t4_sdata_out", bus.sdata_out, 32'h0);
    idle(2);
    n_reset = 1'b1;
    idle(1);
    rd(A_CTRL, 32'h0, "t4_status");
    rd(A_A1, 32'h0, "t4_a1");
    rd(A_W, 32'h0, "t4_w");
    run_op(32'h5, 32'h6);
    rd(A_CTRL, 32'h3, "t4_status_done");
    rd(A_W, 32'h1E, "t4_w_done");
    rd(A_L, 32'h4, "t4_l_done");
    idle(1);
    chk("t4_gpio_out_done", gpio_out, 32'h1);
    chk("t4_gpio_out2", gpio_out2, 32'h1);

    // Counter wrap on the 2-bit instance
    run_op(32'h2, 32'h3);
    run_op(32'h4, 32'h4);
    chk("t5_gpio_out2_3", gpio_out2, 32'h3);
    run_op(32'h1, 32'h1);
    chk("t5_gpio_out", gpio_out, 32'h4);
    chk("t5_gpio_out2_wrap", gpio_out2, 32'h0);
    rd(A_W, 32'h1, "t5_w");

    // GPIO snapshot, unmapped address, read-during-write
    gpio_in = 32'hA5A5_A5A5;
    gpio_latch = 1'b1;
    idle(1);
    gpio_latch = 1'b0;
    gpio_in = 32'h1234_5678;
    idle(2);
    chk("t6_insp", gpio_in_s_insp, 32'hA5A5_A5A5);
    wr(A_BAD, 32'hDEAD_BEEF);
    rd(A_BAD, 32'h0, "t6_bad_addr");
    rd(A_A1, 32'h1, "t6_a1_untouched");
    drive(1'b1, 1'b1, A_A2, 32'h55, 32'h1, "t6_rdwr_old");
    rd(A_A2, 32'h55, "t6_rdwr_new");
    idle(3);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
